// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects operand A, operand B and an opcode byte from a
// UART receiver, presents them to an external combinational ALU, then hands
// the ALU result to a UART transmitter and waits for it to finish the byte.
module alu_uart_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic        [NB_DATA-1:0] i_rx_data,
  input  logic                      i_rx_done,
  input  logic                      i_tx_done,
  input  logic signed [NB_DATA-1:0] i_alu_result,
  output logic signed [NB_DATA-1:0] o_alu_data_A,
  output logic signed [NB_DATA-1:0] o_alu_data_B,
  output logic        [NB_OP-1:0]   o_alu_op,
  output logic        [NB_DATA-1:0] o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  state_t state;
  state_t state_next;

  // One-cycle load strobes decoded from the current state and inputs.
  logic cap_a;
  logic cap_b;
  logic cap_op;
  logic exec;

  // Next-state and load-strobe decode; rx bytes outside the three capture
  // states fall through the defaults and are therefore dropped.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    exec       = 1'b0;
    case (state)
      WAIT_A: begin
        if (i_rx_done) begin
          cap_a      = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          cap_b      = 1'b1;
          state_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          cap_op     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        exec       = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is tested inside the clocked block only (not in the
    // sensitivity list), so it acts synchronously and wins over every event.
    if (!i_rst_n) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Operand, opcode and result registers plus the tx_start pulse.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      o_alu_data_A <= '0;
      o_alu_data_B <= '0;
      o_alu_op     <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
    end else begin
      // EXEC lasts exactly one cycle, so this can never be high twice in a row.
      o_tx_start <= exec;
      if (cap_a) begin
        o_alu_data_A <= i_rx_data;
      end
      if (cap_b) begin
        o_alu_data_B <= i_rx_data;
      end
      if (cap_op) begin
        // Upper bits of the opcode byte are discarded; undefined codes pass.
        o_alu_op <= i_rx_data[NB_OP-1:0];
      end
      if (exec) begin
        o_tx_data <= i_alu_result;
      end
    end
  end

  assign o_busy = (state == EXEC) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed testbench for alu_uart_interface with a small behavioural ALU
// closing the loop between the operand outputs and i_alu_result.
module tb_alu_uart_interface;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;

  int tests_run;
  int tests_failed;
  int double_start;
  logic prev_start;

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_alu_data_A (alu_a),
    .o_alu_data_B (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; undefined opcodes yield a recognisable marker value.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      6'h03:   alu_result = $signed(alu_a) >>> alu_b;
      6'h02:   alu_result = alu_a >> alu_b;
      default: alu_result = 8'hEE;
    endcase
  end

  // Watch for tx_start high on two consecutive cycles.
  always @(negedge clk) begin
    if (tx_start && prev_start) double_start <= double_start + 1;
    prev_start <= tx_start;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Pulse tx_done for one edge and confirm the block is idle again.
  task automatic finish_tx(input string tag, input logic [7:0] exp_res);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_tx_hold"}, tx_data, exp_res);
  endtask

  // Full A, B, OP sequence with latency checks of the tx_start pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op_byte, input logic [7:0] exp_op,
                        input logic [7:0] exp_res);
    send_byte(a);
    send_byte(b);
    send_byte(op_byte);
    // Between edges k and k+1: EXEC.
    check({tag, "_op"}, alu_op, exp_op);
    check({tag, "_exec_busy"}, busy, 1'b1);
    check({tag, "_exec_start"}, tx_start, 1'b0);
    @(negedge clk);
    // Between edges k+1 and k+2: start pulse with the result.
    check({tag, "_start"}, tx_start, 1'b1);
    check({tag, "_result"}, tx_data, exp_res);
    @(negedge clk);
    check({tag, "_start_end"}, tx_start, 1'b0);
    check({tag, "_wait_busy"}, busy, 1'b1);
  endtask

  initial begin
    int n_start;
    int busy_low;
    tests_run    = 0;
    tests_failed = 0;
    double_start = 0;
    prev_start   = 1'b0;
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", alu_a, 8'h00);
    check("rst_b", alu_b, 8'h00);
    check("rst_op", {2'b00, alu_op}, 8'h00);
    check("rst_tx", tx_data, 8'h00);
    check("rst_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    run_op("add", 8'h0A, 8'h05, 8'h20, 8'h20, 8'h0F);
    finish_tx("add", 8'h0F);
    run_op("sra", 8'hF0, 8'h02, 8'h03, 8'h03, 8'hFC);
    finish_tx("sra", 8'hFC);
    run_op("sub", 8'h0F, 8'h05, 8'h22, 8'h22, 8'h0A);
    finish_tx("sub", 8'h0A);
    run_op("and_trunc", 8'hCC, 8'hAA, 8'hE4, 8'h24, 8'h88);

    // rx pulse coincident with tx_done in WAIT_TX: byte dropped, back to WAIT_A.
    rx_data = 8'h55;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("drop_busy", busy, 1'b0);
    check("drop_a", alu_a, 8'hCC);
    check("drop_b", alu_b, 8'hAA);
    run_op("after_drop", 8'h03, 8'h04, 8'h20, 8'h20, 8'h07);
    finish_tx("after_drop", 8'h07);

    // Stray tx_done in WAIT_B and WAIT_OP is ignored; undefined opcode forwarded.
    send_byte(8'h01);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_b_busy", busy, 1'b0);
    send_byte(8'h02);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_op_b", alu_b, 8'h02);
    send_byte(8'hFF);
    check("undef_op", {2'b00, alu_op}, 8'h3F);
    check("undef_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    check("undef_result", tx_data, 8'hEE);
    finish_tx("undef", 8'hEE);

    // Reset after operand A only discards the partial sequence.
    send_byte(8'h77);
    check("partial_a", alu_a, 8'h77);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_a", alu_a, 8'h00);
    check("midrst_tx", tx_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    run_op("or_fresh", 8'h11, 8'h22, 8'h25, 8'h25, 8'h33);
    finish_tx("or_fresh", 8'h33);

    // tx_done withheld for 100 cycles while rx bytes keep arriving.
    send_byte(8'h09);
    send_byte(8'h03);
    send_byte(8'h22);
    n_start  = 0;
    busy_low = 0;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) @(negedge clk);
      rx_done = 1'b0;
      if (tx_start) n_start++;
      if (!busy) busy_low++;
      if (i % 7 == 3) begin
        rx_data = 8'hA0 + 8'(i);
        rx_done = 1'b1;
      end
    end
    @(negedge clk);
    rx_done = 1'b0;
    check("stall_pulses", 8'(n_start), 8'd1);
    check("stall_busy_low", 8'(busy_low), 8'd0);
    check("stall_a", alu_a, 8'h09);
    check("stall_b", alu_b, 8'h03);
    check("stall_op", {2'b00, alu_op}, 8'h22);
    check("stall_tx", tx_data, 8'h06);
    finish_tx("stall", 8'h06);

    // Reset during WAIT_TX.
    run_op("xor", 8'h5A, 8'hFF, 8'h26, 8'h26, 8'hA5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("txrst_busy", busy, 1'b0);
    check("txrst_tx", tx_data, 8'h00);
    check("txrst_op", {2'b00, alu_op}, 8'h00);

    repeat (2) @(negedge clk);
    check("no_double_start", 8'(double_start), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
